// File: rtl/timing_multi.sv
// Multi-channel trigger-delay timer: after an accepted trigger edge, each enabled
// channel emits one start_collect pulse after its own tick-based delay.
module timing_multi #(
  parameter int NUM_CH   = 4,
  parameter int DELAY_W  = 14,
  parameter int WIDTH_W  = 8,
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                      clk100,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [NUM_CH*DELAY_W-1:0] delay,
  input  logic [NUM_CH*WIDTH_W-1:0] pulse_width,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [NUM_CH-1:0]         start_collect,
  output logic                      busy,
  output logic                      done,
  output logic                      missed_trigger,
  output logic [CNT_W-1:0]          trig_count
);

  // state     | meaning
  // ST_IDLE   | waiting for a trigger rising edge
  // ST_RUN    | prescaler/tick counter running, channels firing
  // ST_FINISH | one-cycle done pulse; trigger edges here are missed

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int TICK_W = DELAY_W + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t                    state, state_d;
  logic                      trig_q, armed, trig_edge;
  logic [PRE_W-1:0]          pre, pre_d, pre_nx;
  logic [TICK_W-1:0]         tick, tick_d, tick_nx;
  logic                      pre_wrap;
  logic [NUM_CH*DELAY_W-1:0] sh_delay, sh_delay_d;
  logic [NUM_CH*WIDTH_W-1:0] sh_width, sh_width_d;
  logic [NUM_CH-1:0]         sh_en, sh_en_d;
  logic [NUM_CH-1:0]         complete, complete_d;
  logic [NUM_CH*WIDTH_W-1:0] wcnt, wcnt_d;
  logic [NUM_CH-1:0]         sc_d;
  logic                      busy_d, done_d, missed_d, all_done;
  logic [CNT_W-1:0]          count_d;

  // Remaining high cycles after the first one; a width of 0 behaves like 1.
  function automatic logic [WIDTH_W-1:0] width_load(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? '0 : w - WIDTH_W'(1);
  endfunction

  // armed blocks a trigger that was already high through reset from looking like an edge.
  assign trig_edge = trigger & ~trig_q & armed;
  assign pre_wrap  = (pre == PRE_LAST);
  assign pre_nx    = pre_wrap ? '0 : pre + PRE_W'(1);
  assign tick_nx   = (pre_wrap && tick != '1) ? tick + TICK_W'(1) : tick;

  always_comb begin
    state_d    = state;
    pre_d      = pre;
    tick_d     = tick;
    sh_delay_d = sh_delay;
    sh_width_d = sh_width;
    sh_en_d    = sh_en;
    complete_d = complete;
    wcnt_d     = wcnt;
    sc_d       = start_collect;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    missed_d   = 1'b0;
    count_d    = trig_count;
    all_done   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (trig_edge) begin
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          count_d    = trig_count + CNT_W'(1);
          pre_d      = '0;
          tick_d     = '0;
          sh_delay_d = delay;
          sh_width_d = pulse_width;
          sh_en_d    = ch_enable;
          // Zero-delay channels must already be high on the first RUN cycle.
          for (int i = 0; i < NUM_CH; i++) begin
            complete_d[i] = ~ch_enable[i];
            sc_d[i]       = ch_enable[i] && (delay[i*DELAY_W +: DELAY_W] == '0);
            wcnt_d[i*WIDTH_W +: WIDTH_W] = width_load(pulse_width[i*WIDTH_W +: WIDTH_W]);
          end
        end
      end
      ST_RUN: begin
        missed_d = trig_edge;
        pre_d    = pre_nx;
        tick_d   = tick_nx;
        for (int i = 0; i < NUM_CH; i++) begin
          if (start_collect[i]) begin
            if (wcnt[i*WIDTH_W +: WIDTH_W] == '0) begin
              sc_d[i]       = 1'b0;
              complete_d[i] = 1'b1;
            end else begin
              wcnt_d[i*WIDTH_W +: WIDTH_W] = wcnt[i*WIDTH_W +: WIDTH_W] - WIDTH_W'(1);
            end
          end else if (!complete[i] && sh_en[i] && pre_nx == '0 &&
                       tick_nx == {1'b0, sh_delay[i*DELAY_W +: DELAY_W]}) begin
            sc_d[i] = 1'b1;
            wcnt_d[i*WIDTH_W +: WIDTH_W] = width_load(sh_width[i*WIDTH_W +: WIDTH_W]);
          end
          all_done = all_done & complete_d[i];
        end
        if (all_done) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_FINISH: begin
        missed_d = trig_edge;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state          <= ST_IDLE;
      trig_q         <= 1'b0;
      armed          <= ~trigger;
      pre            <= '0;
      tick           <= '0;
      sh_delay       <= '0;
      sh_width       <= '0;
      sh_en          <= '0;
      complete       <= '0;
      wcnt           <= '0;
      start_collect  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      missed_trigger <= 1'b0;
      trig_count     <= '0;
    end else begin
      state          <= state_d;
      trig_q         <= trigger;
      armed          <= armed | ~trigger;
      pre            <= pre_d;
      tick           <= tick_d;
      sh_delay       <= sh_delay_d;
      sh_width       <= sh_width_d;
      sh_en          <= sh_en_d;
      complete       <= complete_d;
      wcnt           <= wcnt_d;
      start_collect  <= sc_d;
      busy           <= busy_d;
      done           <= done_d;
      missed_trigger <= missed_d;
      trig_count     <= count_d;
    end
  end

endmodule
